// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the HI/LO multiply/divide unit.
// Revision: 1.0
`default_nettype none

package mdu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on unsigned magnitudes.
// Revision: 1.0
`default_nettype none

module mdu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] divisor,
  input  logic              dividend_bit,
  output logic [DATA_W:0]   rem_out,
  output logic              q_bit
);

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;

  // The extra top bit turns the trial subtract's borrow into a plain sign bit.
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[DATA_W+1];
  assign rem_out = q_bit ? diff[DATA_W:0] : shifted[DATA_W:0];

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Revision: 1.0
`default_nettype none

module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              hilo_we,
  input  logic              hilo_sel,
  input  logic [DATA_W-1:0] hilo_wdata,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                op_signed;
  logic                res_neg;
  logic                dvd_neg;
  logic                dbz_flag;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   raw_rs;
  logic [DATA_W:0]     rem;

  logic                sgn_op;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [DATA_W-1:0]   add_term;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_next;
  logic                q_bit;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign busy   = (state != S_IDLE);
  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign rs_mag = (sgn_op && rs_data[DATA_W-1]) ? -rs_data : rs_data;
  assign rt_mag = (sgn_op && rt_data[DATA_W-1]) ? -rt_data : rt_data;

  // Multiplier lives in acc's low half and is consumed LSB-first as the product shifts in.
  assign add_term = acc[0] ? mcand : '0;
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, add_term};

  mdu_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_in       (rem),
    .divisor      (mcand),
    .dividend_bit (quo[DATA_W-1]),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  assign prod_fix = (op_signed && res_neg) ? -acc : acc;
  assign quo_fix  = (op_signed && res_neg) ? -quo : quo;
  assign rem_fix  = (op_signed && dvd_neg) ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      op_signed   <= 1'b0;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
      dbz_flag    <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      quo         <= '0;
      raw_rs      <= '0;
      rem         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt       <= '0;
            is_div    <= op[1];
            op_signed <= sgn_op;
            res_neg   <= rs_data[DATA_W-1] ^ rt_data[DATA_W-1];
            dvd_neg   <= rs_data[DATA_W-1];
            dbz_flag  <= op[1] && (rt_data == '0);
            raw_rs    <= rs_data;
            acc       <= {{DATA_W{1'b0}}, rt_mag};
            mcand     <= op[1] ? rt_mag : rs_mag;
            quo       <= rs_mag;
            rem       <= '0;
            state     <= op[1] ? S_DIV : S_MUL;
          end else if (hilo_we) begin
            if (hilo_sel) begin
              hi <= hilo_wdata;
            end else begin
              lo <= hilo_wdata;
            end
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[DATA_W-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= S_FIX;
          end
        end
        S_DIV: begin
          // Dividend bits shift out of quo's top while quotient bits fill from the bottom.
          rem <= rem_next;
          quo <= {quo[DATA_W-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div) begin
            if (dbz_flag) begin
              lo <= '1;
              hi <= raw_rs;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done        <= 1'b1;
          div_by_zero <= dbz_flag;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed plus randomized checks of mdu_hilo against an arithmetic model.
// Revision: 1.0
`default_nettype none

module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          failures;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_hilo #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hilo_we     (hilo_we),
    .hilo_sel    (hilo_sel),
    .hilo_wdata  (hilo_wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Architectural result straight from integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mz);
    longint      sa;
    longint      sb;
    longint      p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mz = 1'b0;
    mh = '0;
    ml = '0;
    if (o == 2'b00) begin
      p = sa * sb;
      {mh, ml} = p;
    end else if (o == 2'b01) begin
      u = {32'b0, a} * {32'b0, b};
      {mh, ml} = u;
    end else if (b == 32'd0) begin
      ml = 32'hFFFF_FFFF;
      mh = a;
      mz = 1'b1;
    end else if (o == 2'b10) begin
      p  = sa / sb;
      ml = p[31:0];
      p  = sa % sb;
      mh = p[31:0];
    end else begin
      ml = a / b;
      mh = a % b;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic we, input logic sel, input logic [31:0] wd);
    @(negedge clk);
    start      = 1'b1;
    op         = o;
    rs_data    = a;
    rt_data    = b;
    hilo_we    = we;
    hilo_sel   = sel;
    hilo_wdata = wd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    hilo_we = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    op      = 2'($urandom);
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic finish_op(input int n0, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input string tag, input bit check_fall);
    int   n;
    logic mz;
    n = n0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    model(o, a, b, exp_hi, exp_lo, mz);
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
    chk({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
    chk({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, mz});
    if (check_fall) begin
      @(posedge clk);
      #1;
      chk({tag, "_done_fall"}, {62'b0, done, div_by_zero}, 64'd0);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit check_fall);
    launch(o, a, b, 1'b0, 1'b0, 32'h0);
    finish_op(0, o, a, b, tag, check_fall);
  endtask

  task automatic idle_write(input logic sel, input logic [31:0] wd);
    @(negedge clk);
    hilo_we    = 1'b1;
    hilo_sel   = sel;
    hilo_wdata = wd;
    @(posedge clk);
    #1;
    hilo_we = 1'b0;
    if (sel) exp_hi = wd;
    else     exp_lo = wd;
    chk("mt_hi", {32'b0, hi}, {32'b0, exp_hi});
    chk("mt_lo", {32'b0, lo}, {32'b0, exp_lo});
    chk("mt_no_done", {63'b0, done}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    op         = 2'b00;
    rs_data    = '0;
    rt_data    = '0;
    hilo_we    = 1'b0;
    hilo_sel   = 1'b0;
    hilo_wdata = '0;
    exp_hi     = '0;
    exp_lo     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2", 1'b1);
    chk("mult_neg1x2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max_x2", 1'b1);
    chk("multu_max_x2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b1);
    chk("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b11, 32'd100, 32'd7, "divu_100_7", 1'b1);
    do_op(2'b11, 32'h1234_5678, 32'd0, "divu_by0", 1'b1);
    chk("divu_by0_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, "div_by0", 1'b1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // start and MTHI while busy must both be ignored
    launch(2'b00, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start      = 1'b1;
    op         = 2'b11;
    rs_data    = 32'd9;
    rt_data    = 32'd3;
    hilo_we    = 1'b1;
    hilo_sel   = 1'b1;
    hilo_wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    start   = 1'b0;
    hilo_we = 1'b0;
    chk("busy_hold", {63'b0, busy}, 64'd1);
    finish_op(10, 2'b00, 32'd3, 32'd5, "ignore_busy", 1'b1);

    // asynchronous reset mid-divide
    launch(2'b10, 32'hDEAD_0001, 32'd37, 1'b0, 1'b0, 32'h0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b01, 32'd6, 32'd7, "multu_6_7", 1'b1);

    idle_write(1'b1, 32'hDEAD_BEEF);
    idle_write(1'b0, 32'h0BAD_F00D);

    // start wins over a same-cycle MTHI
    launch(2'b01, 32'd2, 32'd2, 1'b1, 1'b1, 32'h1234_5678);
    finish_op(0, 2'b01, 32'd2, 32'd2, "start_prio", 1'b0);

    // back-to-back launch in the done cycle
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "b2b_first", 1'b0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, "b2b_second", 1'b1);

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) idle_write(1'($urandom), $urandom);
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      do_op(ro, ra, rb, "rand", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
